cpu6_trap_ctrl: RTL

CPU6_TRAP_CTRL -- requirements
Module: cpu6_trap_ctrl

---
 rtl/cpu6_trap_ctrl_pkg.sv | 15 +
 rtl/cpu6_trap_ctrl_irq_pri.sv | 27 ++
 rtl/cpu6_trap_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu6_trap_ctrl_pkg.sv
// Shared trap-controller encodings: FSM states, interrupt cause codes, drain counter sizing.
package cpu6_trap_ctrl_pkg;

   typedef enum logic [1:0] {
      CPU6_TRAP_IDLE  = 2'd0,
      CPU6_TRAP_DRAIN = 2'd1,
      CPU6_TRAP_TRAP  = 2'd2
   } trapState_t;

   localparam int                       CPU6_TRAP_CNT_W     = 4;
   localparam logic [CPU6_TRAP_CNT_W-1:0] CPU6_TRAP_CNT_MAX = '1;
   localparam logic [31:0]              CPU6_TRAP_CAUSE_EXT = 32'h8000_000B;
   localparam logic [31:0]              CPU6_TRAP_CAUSE_TMR = 32'h8000_0007;

endpackage

// File: rtl/cpu6_trap_ctrl_irq_pri.sv
// Interrupt qualification and priority encode (external beats timer); purely combinational.
module cpu6_irq_pri
   import cpu6_trap_ctrl_pkg::*;
(
   input  logic        tmrIrq,
   input  logic        extIrq,
   input  logic        mtie,
   input  logic        meie,
   input  logic        mie,
   output logic        pending,
   output logic [31:0] cause
);

   logic pendingExt;
   logic pendingTmr;

   assign pendingExt = extIrq & meie & mie;
   assign pendingTmr = tmrIrq & mtie & mie;
   assign pending    = pendingExt | pendingTmr;

   always_comb begin
      cause = 32'h0;
      if (pendingExt)      cause = CPU6_TRAP_CAUSE_EXT;
      else if (pendingTmr) cause = CPU6_TRAP_CAUSE_TMR;
   end

endmodule

// File: rtl/cpu6_trap_ctrl.sv
// Interrupt trap sequencer: drains the pipeline, then emits one trap cycle (mepc/mcause/vector).
// MRET is handled combinationally in IDLE; a drain that never acks times out back to IDLE.
module cpu6_trap_ctrl
   import cpu6_trap_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        tmr_irq_r,
   input  logic        ext_irq_r,
   input  logic        csr_mtie_r,
   input  logic        csr_meie_r,
   input  logic        csr_mstatus_mie_r,
   input  logic [31:0] csr_mtvec,
   input  logic [31:0] csr_mepc,
   input  logic [31:0] resume_pc,
   input  logic        mret_decE,
   input  logic        empty_pipeline_ackW,
   output logic        empty_pipeline_reqE,
   output logic        stallF,
   output logic [31:0] excp_pc,
   output logic        excp_pc_ena,
   output logic [31:0] excp_mepc,
   output logic        excp_mepc_ena,
   output logic [31:0] excp_mcause,
   output logic        mret_ena,
   output logic        drain_timeout
);

   trapState_t                 state;
   trapState_t                 nextState;
   logic [31:0]                savedPc;
   logic [31:0]                savedCause;
   logic [CPU6_TRAP_CNT_W-1:0] drainCnt;
   logic                       drainTimeout;
   logic                       irqPending;
   logic [31:0]                irqCause;

   cpu6_irq_pri uIrqPri (
      .tmrIrq  (tmr_irq_r),
      .extIrq  (ext_irq_r),
      .mtie    (csr_mtie_r),
      .meie    (csr_meie_r),
      .mie     (csr_mstatus_mie_r),
      .pending (irqPending),
      .cause   (irqCause)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= CPU6_TRAP_IDLE;
         savedPc      <= 32'h0;
         savedCause   <= 32'h0;
         drainCnt     <= '0;
         drainTimeout <= 1'b0;
      end else begin
         state <= nextState;
         case (state)
            CPU6_TRAP_IDLE: begin
               // The trap is committed here; later irq deassertion cannot cancel it.
               if (!mret_decE && irqPending) begin
                  savedPc    <= resume_pc;
                  savedCause <= irqCause;
                  drainCnt   <= '0;
               end
            end
            CPU6_TRAP_DRAIN: begin
               if (!empty_pipeline_ackW) begin
                  if (drainCnt == CPU6_TRAP_CNT_MAX) drainTimeout <= 1'b1;
                  else                               drainCnt     <= drainCnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nextState           = state;
      empty_pipeline_reqE = 1'b0;
      stallF              = 1'b0;
      excp_pc             = 32'h0;
      excp_pc_ena         = 1'b0;
      excp_mepc           = 32'h0;
      excp_mepc_ena       = 1'b0;
      excp_mcause         = 32'h0;
      mret_ena            = 1'b0;
      // Reset gates every output so an aborted drain/trap never leaks a strobe.
      if (!reset) begin
         case (state)
            CPU6_TRAP_IDLE: begin
               if (mret_decE) begin
                  mret_ena    = 1'b1;
                  excp_pc     = csr_mepc;
                  excp_pc_ena = 1'b1;
               end else if (irqPending) begin
                  nextState = CPU6_TRAP_DRAIN;
               end
            end
            CPU6_TRAP_DRAIN: begin
               stallF              = 1'b1;
               empty_pipeline_reqE = (drainCnt == '0);
               if (empty_pipeline_ackW)                 nextState = CPU6_TRAP_TRAP;
               else if (drainCnt == CPU6_TRAP_CNT_MAX)  nextState = CPU6_TRAP_IDLE;
            end
            CPU6_TRAP_TRAP: begin
               stallF        = 1'b1;
               excp_mepc     = savedPc;
               excp_mepc_ena = 1'b1;
               excp_mcause   = savedCause;
               excp_pc       = csr_mtvec;
               excp_pc_ena   = 1'b1;
               nextState     = CPU6_TRAP_IDLE;
            end
            default: nextState = CPU6_TRAP_IDLE;
         endcase
      end
   end

   assign drain_timeout = drainTimeout & ~reset;

endmodule
